// File: rtl/pdm_ramp_pkg.sv
// Shared types and default widths for the PDM setpoint ramp generator.
//   ST_IDLE     : no ramp in progress, output holds
//   ST_LOAD     : one-cycle check of a freshly latched target
//   ST_RAMP     : output slewing toward the latched target once per tick
package pdm_ramp_pkg;

  localparam int unsigned NBITS_DEF   = 11;
  localparam int unsigned PS_BITS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RAMP = 2'd2
  } state_t;

endpackage

// File: rtl/pdm_ramp_tick.sv
// Prescale tick generator: while en is high, pulses tick once every period+1 clocks.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   clr    : restarts the count from zero (takes priority over en)
//   en     : counting enable
//   period : tick period minus one, in clk cycles
//   tick   : high in the cycle where the count has reached period
module pdm_ramp_tick
  import pdm_ramp_pkg::*;
#(
  parameter int unsigned PS_BITS = PS_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PS_BITS-1:0] period,
  output logic               tick
);

  logic [PS_BITS-1:0] count;

  assign tick = en && (count == period);

  // Free-running prescale counter, wraps to zero on each tick
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + PS_BITS'(1);
    end
  end

endmodule

// File: rtl/pdm_ramp.sv
// Slew-rate-limited setpoint generator feeding the din input of a PDM modulator.
// A new target is accepted over a valid/ready handshake; the output then moves
// toward it by at most step per tick, with one tick every prescale+1 clocks.
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   target       : requested level (unsigned)
//   step         : max change per tick (0 behaves as 1)
//   prescale     : tick period minus one, in clk cycles
//   target_valid : target/step/prescale valid this cycle
//   target_ready : a new target can be accepted this cycle
//   dout         : current level, to the modulator's din
//   busy         : high while a target is being loaded or ramped to
//   done         : one-cycle pulse when dout reaches the latched target
module pdm_ramp
  import pdm_ramp_pkg::*;
#(
  parameter int unsigned NBITS   = NBITS_DEF,
  parameter int unsigned PS_BITS = PS_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NBITS-1:0]   target,
  input  logic [NBITS-1:0]   step,
  input  logic [PS_BITS-1:0] prescale,
  input  logic               target_valid,
  output logic               target_ready,
  output logic [NBITS-1:0]   dout,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [NBITS-1:0]   target_reg;
  logic [NBITS-1:0]   step_reg;
  logic [PS_BITS-1:0] ps_reg;

  logic               xfer_c;
  logic               tick_c;
  logic               ramp_en_c;
  logic               up_c;
  logic               close_c;
  logic [NBITS:0]     diff_c;

  // Ready is forced low during reset so no transfer can be lost to it
  assign target_ready = !rst && ((state == ST_IDLE) || (state == ST_RAMP));
  assign xfer_c       = target_valid && target_ready;
  assign ramp_en_c    = (state == ST_RAMP);

  pdm_ramp_tick #(
    .PS_BITS (PS_BITS)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (xfer_c),
    .en     (ramp_en_c),
    .period (ps_reg),
    .tick   (tick_c)
  );

  // Distance to target in one extra bit; within one step means land exactly
  always_comb begin
    up_c    = 1'b0;
    diff_c  = '0;
    close_c = 1'b0;
    up_c    = (target_reg > dout);
    if (up_c) begin
      diff_c = {1'b0, target_reg} - {1'b0, dout};
    end else begin
      diff_c = {1'b0, dout} - {1'b0, target_reg};
    end
    close_c = (diff_c <= {1'b0, step_reg});
  end

  // Control FSM with latched command and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dout       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      target_reg <= '0;
      step_reg   <= NBITS'(1);
      ps_reg     <= '0;
    end else begin
      done <= 1'b0;
      if (xfer_c) begin
        // A new command always wins over a coincident tick; dout holds
        target_reg <= target;
        step_reg   <= (step == '0) ? NBITS'(1) : step;
        ps_reg     <= prescale;
        state      <= ST_LOAD;
        busy       <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_LOAD: begin
            if (target_reg == dout) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_RAMP;
            end
          end
          ST_RAMP: begin
            if (tick_c) begin
              if (close_c) begin
                dout  <= target_reg;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else if (up_c) begin
                dout <= dout + step_reg;
              end else begin
                dout <= dout - step_reg;
              end
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pdm_ramp.sv
// Self-checking bench for pdm_ramp: expected (level, cycle) pairs are queued
// when a command is issued and compared against observed dout changes.
module tb_pdm_ramp;

  localparam int unsigned NBITS   = 11;
  localparam int unsigned PS_BITS = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NBITS-1:0]   target = '0;
  logic [NBITS-1:0]   step = '0;
  logic [PS_BITS-1:0] prescale = '0;
  logic               target_valid = 1'b0;
  logic               target_ready;
  logic [NBITS-1:0]   dout;
  logic               busy;
  logic               done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  int last_dout = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int obs_val_q[$];
  int obs_cyc_q[$];
  int exp_val_q[$];
  int exp_cyc_q[$];

  pdm_ramp #(
    .NBITS   (NBITS),
    .PS_BITS (PS_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .target       (target),
    .step         (step),
    .prescale     (prescale),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .dout         (dout),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every dout change and every done pulse
  always @(posedge clk) begin
    #1;
    if (int'(dout) != last_dout) begin
      obs_val_q.push_back(int'(dout));
      obs_cyc_q.push_back(cyc);
      last_dout = int'(dout);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    @(negedge clk);
    obs_val_q.delete();
    obs_cyc_q.delete();
    exp_val_q.delete();
    exp_cyc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns after the transfer edge
  task automatic send(input int t, input int s, input int p);
    int waitc;
    waitc = 0;
    target       = NBITS'(t);
    step         = NBITS'(s);
    prescale     = PS_BITS'(p);
    target_valid = 1'b1;
    while (target_ready !== 1'b1 && waitc < 20) begin
      step_clk(1);
      waitc++;
    end
    if (target_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_ready: target_ready=%b, required 1", target_ready);
    end
    @(posedge clk);
    #1;
    xfer_cyc     = cyc;
    target_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_clk(2);
    rst = 1'b0;
    step_clk(2);
    clear_obs();
  endtask

  task automatic go_to(input int level);
    send(level, 2047, 0);
    step_clk(4);
    clear_obs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step_clk(2);
    tests++;
    if (dout !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: dout=%0d busy=%b done=%b, required 0 0 0", dout, busy, done);
    end
    tests++;
    if (target_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_low: target_ready=%b, required 0", target_ready);
    end
    rst = 1'b0;
    step_clk(1);
    tests++;
    if (target_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_high: target_ready=%b, required 1", target_ready);
    end
    step_clk(1);
    clear_obs();
  endtask

  task automatic test_up_ramp();
    int ev, ec, ov, oc;
    do_reset();
    send(100, 10, 0);
    for (int k = 1; k <= 10; k++) begin
      exp_val_q.push_back(10 * k);
      exp_cyc_q.push_back(xfer_cyc + 1 + k);
    end
    step_clk(15);
    tests++;
    if (obs_val_q.size() != exp_val_q.size()) begin
      fails++;
      $display("FAIL up_count: %0d changes, required %0d", obs_val_q.size(), exp_val_q.size());
    end
    while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
      ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
      tests++;
      if (ov != ev || oc != ec) begin
        fails++;
        $display("FAIL up_step: dout=%0d at cycle %0d, required %0d at cycle %0d", ov, oc, ev, ec);
      end
    end
    tests++;
    if (done_cnt != 1 || done_cyc != xfer_cyc + 11) begin
      fails++;
      $display("FAIL up_done: %0d pulses last at %0d, required 1 at %0d", done_cnt, done_cyc, xfer_cyc + 11);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL up_busy: busy=%b, required 0", busy);
    end
    clear_obs();
  endtask

  task automatic test_nondivisible();
    int ev, ec, ov, oc;
    do_reset();
    send(25, 10, 0);
    exp_val_q = '{10, 20, 25};
    exp_cyc_q = '{xfer_cyc + 2, xfer_cyc + 3, xfer_cyc + 4};
    step_clk(8);
    tests++;
    if (obs_val_q.size() != exp_val_q.size()) begin
      fails++;
      $display("FAIL nondiv_count: %0d changes, required %0d", obs_val_q.size(), exp_val_q.size());
    end
    while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
      ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
      tests++;
      if (ov != ev || oc != ec) begin
        fails++;
        $display("FAIL nondiv_step: dout=%0d at cycle %0d, required %0d at cycle %0d", ov, oc, ev, ec);
      end
    end
    tests++;
    if (done_cnt != 1 || done_cyc != xfer_cyc + 4) begin
      fails++;
      $display("FAIL nondiv_done: %0d pulses last at %0d, required 1 at %0d", done_cnt, done_cyc, xfer_cyc + 4);
    end
    clear_obs();
  endtask

  task automatic test_down_ramp();
    int ev, ec, ov, oc;
    do_reset();
    go_to(100);
    send(0, 30, 3);
    exp_val_q = '{70, 40, 10, 0};
    exp_cyc_q = '{xfer_cyc + 5, xfer_cyc + 9, xfer_cyc + 13, xfer_cyc + 17};
    step_clk(22);
    tests++;
    if (obs_val_q.size() != exp_val_q.size()) begin
      fails++;
      $display("FAIL down_count: %0d changes, required %0d", obs_val_q.size(), exp_val_q.size());
    end
    while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
      ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
      tests++;
      if (ov != ev || oc != ec) begin
        fails++;
        $display("FAIL down_step: dout=%0d at cycle %0d, required %0d at cycle %0d", ov, oc, ev, ec);
      end
    end
    tests++;
    if (done_cnt != 1 || done_cyc != xfer_cyc + 17) begin
      fails++;
      $display("FAIL down_done: %0d pulses last at %0d, required 1 at %0d", done_cnt, done_cyc, xfer_cyc + 17);
    end
    clear_obs();
  endtask

  task automatic test_top_edge();
    do_reset();
    go_to(2040);
    send(2047, 100, 0);
    step_clk(6);
    tests++;
    if (obs_val_q.size() != 1 || dout !== NBITS'(2047)) begin
      fails++;
      $display("FAIL top_edge: dout=%0d after %0d changes, required 2047 after 1", dout, obs_val_q.size());
    end
    tests++;
    if (done_cnt != 1 || done_cyc != xfer_cyc + 2) begin
      fails++;
      $display("FAIL top_done: %0d pulses last at %0d, required 1 at %0d", done_cnt, done_cyc, xfer_cyc + 2);
    end
    clear_obs();
  endtask

  task automatic test_retarget();
    int ev, ec, ov, oc, waitc, x1, x2;
    do_reset();
    send(100, 10, 0);
    x1 = xfer_cyc;
    for (int k = 1; k <= 5; k++) begin
      exp_val_q.push_back(10 * k);
      exp_cyc_q.push_back(x1 + 1 + k);
    end
    waitc = 0;
    while (dout !== NBITS'(50) && waitc < 20) begin
      step_clk(1);
      waitc++;
    end
    tests++;
    if (dout !== NBITS'(50)) begin
      fails++;
      $display("FAIL retarget_reach50: dout=%0d, required 50", dout);
    end
    send(20, 10, 0);
    x2 = xfer_cyc;
    tests++;
    if (dout !== NBITS'(50)) begin
      fails++;
      $display("FAIL retarget_hold: dout=%0d on transfer edge, required 50", dout);
    end
    exp_val_q.push_back(40); exp_cyc_q.push_back(x2 + 2);
    exp_val_q.push_back(30); exp_cyc_q.push_back(x2 + 3);
    exp_val_q.push_back(20); exp_cyc_q.push_back(x2 + 4);
    step_clk(8);
    tests++;
    if (obs_val_q.size() != exp_val_q.size()) begin
      fails++;
      $display("FAIL retarget_count: %0d changes, required %0d", obs_val_q.size(), exp_val_q.size());
    end
    while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
      ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
      tests++;
      if (ov != ev || oc != ec) begin
        fails++;
        $display("FAIL retarget_step: dout=%0d at cycle %0d, required %0d at cycle %0d", ov, oc, ev, ec);
      end
    end
    tests++;
    if (done_cnt != 1 || done_cyc != x2 + 4) begin
      fails++;
      $display("FAIL retarget_done: %0d pulses last at %0d, required 1 at %0d", done_cnt, done_cyc, x2 + 4);
    end
    clear_obs();
  endtask

  task automatic test_corners();
    int ev, ec, ov, oc;
    // Reset while ramping
    do_reset();
    send(100, 10, 3);
    step_clk(10);
    tests++;
    if (dout !== NBITS'(20)) begin
      fails++;
      $display("FAIL rst_mid_pre: dout=%0d, required 20", dout);
    end
    rst = 1'b1;
    step_clk(1);
    tests++;
    if (dout !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: dout=%0d done=%b busy=%b, required 0 0 0", dout, done, busy);
    end
    rst = 1'b0;
    step_clk(6);
    tests++;
    if (dout !== '0 || done_cnt != 0) begin
      fails++;
      $display("FAIL rst_mid_after: dout=%0d done pulses=%0d, required 0 and 0", dout, done_cnt);
    end
    // Zero step behaves as one
    do_reset();
    send(3, 0, 0);
    exp_val_q = '{1, 2, 3};
    exp_cyc_q = '{xfer_cyc + 2, xfer_cyc + 3, xfer_cyc + 4};
    step_clk(8);
    tests++;
    if (obs_val_q.size() != exp_val_q.size()) begin
      fails++;
      $display("FAIL step0_count: %0d changes, required %0d", obs_val_q.size(), exp_val_q.size());
    end
    while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
      ev = exp_val_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_val_q.pop_front(); oc = obs_cyc_q.pop_front();
      tests++;
      if (ov != ev || oc != ec) begin
        fails++;
        $display("FAIL step0_step: dout=%0d at cycle %0d, required %0d at cycle %0d", ov, oc, ev, ec);
      end
    end
    clear_obs();
    // Target equal to current level completes from LOAD
    send(3, 5, 0);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || target_ready !== 1'b0) begin
      fails++;
      $display("FAIL eq_load: busy=%b done=%b ready=%b, required 1 0 0", busy, done, target_ready);
    end
    step_clk(1);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || dout !== NBITS'(3)) begin
      fails++;
      $display("FAIL eq_done: done=%b busy=%b dout=%0d, required 1 0 3", done, busy, dout);
    end
    step_clk(1);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL eq_pulse: done=%b one cycle later, required 0", done);
    end
    step_clk(3);
    tests++;
    if (done_cnt != 1 || obs_val_q.size() != 0) begin
      fails++;
      $display("FAIL eq_total: %0d pulses %0d changes, required 1 and 0", done_cnt, obs_val_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_nondivisible();
    test_down_ramp();
    test_top_edge();
    test_retarget();
    test_corners();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
